// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit-side arbitration logic.
package uart_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int UART_BYTE_W = 8;
    localparam int BYTE_CNT_W  = 16;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: rotate the request vector by rr_ptr_i,
// take the lowest set bit, then rotate the result back to an absolute index.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               valid_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W:0]       offset;
    logic [IDX_W:0]       idx_sum;

    // Doubling the vector lets a plain part-select perform the modulo rotate.
    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl[rr_ptr_i +: NUM_REQ];

    always_comb begin
        offset  = '0;
        valid_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset  = (IDX_W + 1)'(k);
                valid_o = 1'b1;
            end
        end
        idx_sum = {1'b0, rr_ptr_i} + offset;
        if (idx_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            idx_sum = idx_sum - (IDX_W + 1)'(NUM_REQ);
        end
        grant_idx_o = idx_sum[IDX_W-1:0];
        grant_o     = '0;
        if (valid_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART transmit port between NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to build the stalled-owner timeout (TIMEOUT_CYC, timeout_err).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = 2
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           busy,
    output logic [BYTE_CNT_W-1:0]          byte_cnt,
    output logic                           timeout_err
);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [NUM_REQ-1:0]      pick_grant;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_valid;
    logic                    owner_valid;
    logic                    owner_last;
    logic                    xfer;
    logic [IDX_W-1:0]        next_ptr;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick_grant),
        .grant_idx_o (pick_idx),
        .valid_o     (pick_valid)
    );

    assign owner_valid = req_valid[grant_idx_q];
    assign owner_last  = req_last[grant_idx_q];
    assign xfer        = (state_q == GRANT) && owner_valid && tx_ready;
    assign next_ptr    = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state_q == GRANT) begin
            tx_valid  = owner_valid;
            tx_data   = req_data[grant_idx_q*UART_BYTE_W +: UART_BYTE_W];
            req_ready = grant_q & {NUM_REQ{tx_ready}};
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        byte_cnt_d  = byte_cnt_q;
        if (xfer) begin
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = GRANT;
                    grant_d     = pick_grant;
                    grant_idx_d = pick_idx;
                end
            end
            GRANT: begin
                if (xfer && owner_last) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        idle_cnt_d    = '0;
        timeout_err_d = 1'b0;
        // A silent owner is evicted once it has idled TIMEOUT_CYC grant cycles.
        if (state_q == GRANT && !owner_valid) begin
            idle_cnt_d = idle_cnt_q + 16'(1);
            if (idle_cnt_d == 16'(TIMEOUT_CYC)) begin
                state_d       = IDLE;
                grant_d       = '0;
                rr_ptr_d      = next_ptr;
                timeout_err_d = 1'b1;
                idle_cnt_d    = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = (state_q == GRANT);
    assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (4 requesters); the stall
// sequence expects eviction after 8 idle cycles when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        busy;
    logic [15:0] byte_cnt;
    logic        timeout_err;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        rdy;
        logic [3:0]  expGrant;
        logic        expTxValid;
        logic [7:0]  expTxData;
        logic [3:0]  expReqReady;
        logic        expBusy;
        logic [15:0] expCnt;
    } vecT;

    vecT vecs[$];

    uart_tx_arbiter #(
        .NUM_REQ     (4),
`ifdef UART_ARB_TIMEOUT_EN
        .TIMEOUT_CYC (8),
`endif
        .IDX_W       (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .byte_cnt    (byte_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] d,
                                 input logic [3:0] l, input logic rdy);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_data  = d;
        req_last  = l;
        tx_ready  = rdy;
        #1;
    endtask

    function automatic logic [1:0] idxOf(input logic [3:0] oneHot);
        logic [1:0] idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (oneHot[k]) idx = 2'(k);
        end
        return idx;
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] eGrant, input logic eTxValid,
                               input logic [7:0] eTxData, input logic [3:0] eReqReady,
                               input logic eBusy, input logic [15:0] eCnt, input logic eTimeout);
        checkVal({tag, ".grant"}, 32'(grant), 32'(eGrant));
        checkVal({tag, ".tx_valid"}, 32'(tx_valid), 32'(eTxValid));
        checkVal({tag, ".tx_data"}, 32'(tx_data), 32'(eTxData));
        checkVal({tag, ".req_ready"}, 32'(req_ready), 32'(eReqReady));
        checkVal({tag, ".busy"}, 32'(busy), 32'(eBusy));
        checkVal({tag, ".byte_cnt"}, 32'(byte_cnt), 32'(eCnt));
        checkVal({tag, ".timeout_err"}, 32'(timeout_err), 32'(eTimeout));
        if (eBusy) begin
            checkVal({tag, ".grant_idx"}, 32'(grant_idx), 32'(idxOf(eGrant)));
        end
    endtask

    task automatic addVec(input logic r, input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                          input logic rdy, input logic [3:0] eg, input logic etv, input logic [7:0] etd,
                          input logic [3:0] err, input logic eb, input logic [15:0] ec);
        vecT x;
        x = '{r, v, d, l, rdy, eg, etv, etd, err, eb, ec};
        vecs.push_back(x);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Single packet from req0: 0x41 0x42 0x43(last).
        addVec(0, 4'h1, 32'h0000_0041, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd0);
        addVec(0, 4'h1, 32'h0000_0041, 4'h0, 1, 4'h1, 1, 8'h41, 4'h1, 1, 16'd0);
        addVec(0, 4'h1, 32'h0000_0042, 4'h0, 1, 4'h1, 1, 8'h42, 4'h1, 1, 16'd1);
        addVec(0, 4'h1, 32'h0000_0043, 4'h1, 1, 4'h1, 1, 8'h43, 4'h1, 1, 16'd2);
        addVec(0, 4'h0, 32'h0000_0000, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd3);
        // Single-byte packet from req1 moves rr_ptr to 2.
        addVec(0, 4'h2, 32'h0000_1000, 4'h2, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd3);
        addVec(0, 4'h2, 32'h0000_1000, 4'h2, 1, 4'h2, 1, 8'h10, 4'h2, 1, 16'd3);
        // Contention req1+req3 with rr_ptr=2: req3 first, bubble, then req1.
        addVec(0, 4'hA, 32'hD100_A100, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd4);
        addVec(0, 4'hA, 32'hD100_A100, 4'h0, 1, 4'h8, 1, 8'hD1, 4'h8, 1, 16'd4);
        addVec(0, 4'hA, 32'hD200_A100, 4'h8, 1, 4'h8, 1, 8'hD2, 4'h8, 1, 16'd5);
        addVec(0, 4'h2, 32'h0000_A100, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd6);
        addVec(0, 4'h2, 32'h0000_A100, 4'h0, 1, 4'h2, 1, 8'hA1, 4'h2, 1, 16'd6);
        addVec(0, 4'h2, 32'h0000_A200, 4'h2, 1, 4'h2, 1, 8'hA2, 4'h2, 1, 16'd7);
        addVec(0, 4'h0, 32'h0000_0000, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd8);
        // Backpressure on a req2 packet: tx_ready 1,0,0,1.
        addVec(0, 4'h4, 32'h0021_0000, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd8);
        addVec(0, 4'h4, 32'h0021_0000, 4'h0, 1, 4'h4, 1, 8'h21, 4'h4, 1, 16'd8);
        addVec(0, 4'h4, 32'h0022_0000, 4'h4, 0, 4'h4, 1, 8'h22, 4'h0, 1, 16'd9);
        addVec(0, 4'h4, 32'h0022_0000, 4'h4, 0, 4'h4, 1, 8'h22, 4'h0, 1, 16'd9);
        addVec(0, 4'h4, 32'h0022_0000, 4'h4, 1, 4'h4, 1, 8'h22, 4'h4, 1, 16'd9);
        addVec(0, 4'h0, 32'h0000_0000, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd10);
        // Mid-packet reset of a req0 packet, then req1 wins from rr_ptr=0 over req3.
        addVec(0, 4'h1, 32'h0000_0001, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd10);
        addVec(0, 4'h1, 32'h0000_0001, 4'h0, 1, 4'h1, 1, 8'h01, 4'h1, 1, 16'd10);
        addVec(0, 4'h1, 32'h0000_0002, 4'h0, 1, 4'h1, 1, 8'h02, 4'h1, 1, 16'd11);
        addVec(1, 4'h1, 32'h0000_0003, 4'h0, 1, 4'h1, 1, 8'h03, 4'h1, 1, 16'd12);
        addVec(0, 4'hA, 32'h3300_5500, 4'hA, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd0);
        addVec(0, 4'hA, 32'h3300_5500, 4'hA, 1, 4'h2, 1, 8'h55, 4'h2, 1, 16'd0);
        addVec(0, 4'h8, 32'h3300_0000, 4'h8, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd1);
        addVec(0, 4'h8, 32'h3300_0000, 4'h8, 1, 4'h8, 1, 8'h33, 4'h8, 1, 16'd1);
        addVec(0, 4'h0, 32'h0000_0000, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd2);
        // Owner drops valid between bytes; tx_ready alone must not count a byte.
        addVec(0, 4'h4, 32'h0077_0000, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd2);
        addVec(0, 4'h4, 32'h0077_0000, 4'h0, 1, 4'h4, 1, 8'h77, 4'h4, 1, 16'd2);
        addVec(0, 4'h0, 32'h0077_0000, 4'h0, 1, 4'h4, 0, 8'h77, 4'h4, 1, 16'd3);
        addVec(0, 4'h4, 32'h0078_0000, 4'h4, 1, 4'h4, 1, 8'h78, 4'h4, 1, 16'd3);
        addVec(0, 4'h0, 32'h0000_0000, 4'h0, 1, 4'h0, 0, 8'h00, 4'h0, 0, 16'd4);

        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
        repeat (2) applyStimulus(1, 4'h0, 32'h0, 4'h0, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 4'h0, 32'h0, 4'h0, 0);
            checkOutput($sformatf("idle%0d", i), 4'h0, 0, 8'h00, 4'h0, 0, 16'd0, 0);
            if (i == 0) checkVal("idle.grant_idx", 32'(grant_idx), 32'd0);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].rdy);
            checkOutput($sformatf("row%0d", i), vecs[i].expGrant, vecs[i].expTxValid, vecs[i].expTxData,
                        vecs[i].expReqReady, vecs[i].expBusy, vecs[i].expCnt, 1'b0);
        end

        // Stall: rr_ptr=3, req0 and req1 pending; req0 sends one non-last byte and goes silent.
        applyStimulus(0, 4'h3, 32'h0000_B0E0, 4'h2, 1);
        checkOutput("stall.idle", 4'h0, 0, 8'h00, 4'h0, 0, 16'd4, 0);
        applyStimulus(0, 4'h3, 32'h0000_B0E0, 4'h2, 1);
        checkOutput("stall.byte", 4'h1, 1, 8'hE0, 4'h1, 1, 16'd4, 0);
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 4'h2, 32'h0000_B0E0, 4'h2, 1);
            checkOutput($sformatf("stall%0d", i), 4'h1, 0, 8'hE0, 4'h1, 1, 16'd5, 0);
        end
        applyStimulus(0, 4'h2, 32'h0000_B0E0, 4'h2, 1);
        checkOutput("timeout.pulse", 4'h0, 0, 8'h00, 4'h0, 0, 16'd5, 1);
        applyStimulus(0, 4'h2, 32'h0000_B0E0, 4'h2, 1);
        checkOutput("timeout.req1", 4'h2, 1, 8'hB0, 4'h2, 1, 16'd5, 0);
        applyStimulus(0, 4'h0, 32'h0, 4'h0, 1);
        checkOutput("timeout.done", 4'h0, 0, 8'h00, 4'h0, 0, 16'd6, 0);
`else
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, 4'h2, 32'h0000_B0E0, 4'h2, 1);
            checkVal($sformatf("stall%0d.grant", i), 32'(grant), 32'h1);
            checkVal($sformatf("stall%0d.timeout_err", i), 32'(timeout_err), 32'd0);
        end
        applyStimulus(0, 4'h3, 32'h0000_B0E1, 4'h3, 1);
        checkOutput("stall.last", 4'h1, 1, 8'hE1, 4'h1, 1, 16'd5, 0);
        applyStimulus(0, 4'h2, 32'h0000_B000, 4'h2, 1);
        checkOutput("stall.bubble", 4'h0, 0, 8'h00, 4'h0, 0, 16'd6, 0);
        applyStimulus(0, 4'h2, 32'h0000_B000, 4'h2, 1);
        checkOutput("stall.req1", 4'h2, 1, 8'hB0, 4'h2, 1, 16'd6, 0);
        applyStimulus(0, 4'h0, 32'h0, 4'h0, 1);
        checkOutput("stall.done", 4'h0, 0, 8'h00, 4'h0, 0, 16'd7, 0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
